// File: rtl/sram_bus_fifo_responder_if.sv
// AVR external-SRAM bus bundle between the initiator and a windowed responder.
interface sram_bus_fifo_responder_if;
    logic [1:0] bus_a;
    logic [7:0] bus_wdata;
    logic       bus_cs;
    logic       bus_oe;
    logic       bus_we;
    logic [7:0] bus_rdata;
    logic       bus_wait;

    modport master (output bus_a, bus_wdata, bus_cs, bus_oe, bus_we, input bus_rdata, bus_wait);
    modport slave  (input bus_a, bus_wdata, bus_cs, bus_oe, bus_we, output bus_rdata, bus_wait);
endinterface

// File: rtl/sram_bus_fifo_responder.sv
// 4-byte SRAM-bus register window bridged to RX/TX byte FIFOs.
// Define SRAM_RESP_WRSTALL_EN to stall DATA writes on a full TX FIFO instead of dropping them.
module sram_bus_fifo_responder #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned READ_WS      = 1,
    parameter logic [7:0]  STATUS_RESET = 8'h00
) (
    input  logic                            clk,
    input  logic                            nrst,
    sram_bus_fifo_responder_if.slave        bus,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_state_e;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          rx_ie_q, rx_ie_d, tx_drop_q, tx_drop_d;
    rd_state_e     st_q, st_d;
    logic [1:0]    ws_q, ws_d;
    logic [7:0]    head_q, head_d;
    logic          hvalid_q, hvalid_d;

    logic       rx_full, rx_empty, tx_full, tx_empty;
    logic       rd_hit, wr_en, wr_data, wr_ctrl, flush;
    logic       rx_push, rx_pop, tx_push, tx_pop, tx_stall, rd_wait;
    logic [7:0] rx_head, data_rd_val, rd_mux, status, rxcount;
    logic [8:0] rx_cnt9;

    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_head  = rx_mem[rx_rp_q];

    assign rd_hit  = bus.bus_cs & bus.bus_oe & (bus.bus_a == 2'd1);
    assign wr_en   = bus.bus_cs & bus.bus_we;
    assign wr_data = wr_en & (bus.bus_a == 2'd1);
    assign wr_ctrl = wr_en & (bus.bus_a == 2'd2);
    assign flush   = wr_ctrl & bus.bus_wdata[1];

    assign rx_push = rx_valid & ~rx_full;
    assign tx_pop  = ~tx_empty & tx_ready;
    assign tx_push = wr_data & ~tx_full;
`ifdef SRAM_RESP_WRSTALL_EN
    assign tx_stall = wr_data & tx_full;
`else
    assign tx_stall = 1'b0;
`endif

    // DATA read wait sequencer; the access-start cycle is the first wait cycle.
    always_comb begin
        st_d        = st_q;
        ws_d        = ws_q;
        head_d      = head_q;
        hvalid_d    = hvalid_q;
        rx_pop      = 1'b0;
        rd_wait     = 1'b0;
        data_rd_val = 8'h00;
        if (READ_WS == 0) begin
            st_d        = RD_IDLE;
            data_rd_val = rx_empty ? 8'h00 : rx_head;
            rx_pop      = rd_hit & ~rx_empty;
        end else begin
            case (st_q)
                RD_IDLE: begin
                    if (rd_hit) begin
                        rd_wait  = 1'b1;
                        head_d   = rx_empty ? 8'h00 : rx_head;
                        hvalid_d = ~rx_empty;
                        if (READ_WS == 1) begin
                            st_d = RD_DONE;
                        end else begin
                            st_d = RD_WAIT;
                            ws_d = 2'(READ_WS - 2);
                        end
                    end
                end
                RD_WAIT: begin
                    rd_wait = 1'b1;
                    if (!rd_hit)           st_d = RD_IDLE;
                    else if (ws_q == 2'd0) st_d = RD_DONE;
                    else                   ws_d = ws_q - 2'd1;
                end
                RD_DONE: begin
                    data_rd_val = head_q;
                    rx_pop      = rd_hit & hvalid_q & ~rx_empty;
                    st_d        = RD_IDLE;
                end
                default: st_d = RD_IDLE;
            endcase
        end
    end

    // FIFO pointers, counts and control bits; flush overrides any push/pop.
    always_comb begin
        rx_wp_d   = rx_wp_q + AW'(rx_push);
        rx_rp_d   = rx_rp_q + AW'(rx_pop);
        rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        tx_wp_d   = tx_wp_q + AW'(tx_push);
        tx_rp_d   = tx_rp_q + AW'(tx_pop);
        tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_ie_d   = wr_ctrl ? bus.bus_wdata[0] : rx_ie_q;
        tx_drop_d = tx_drop_q;
`ifndef SRAM_RESP_WRSTALL_EN
        if (wr_data && tx_full) tx_drop_d = 1'b1;
`endif
        if (wr_ctrl && bus.bus_wdata[3]) tx_drop_d = 1'b0;
        if (flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st_q      <= RD_IDLE;
            ws_q      <= 2'd0;
            head_q    <= 8'h00;
            hvalid_q  <= 1'b0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_ie_q   <= 1'b0;
            tx_drop_q <= STATUS_RESET[3];
        end else begin
            st_q      <= st_d;
            ws_q      <= ws_d;
            head_q    <= head_d;
            hvalid_q  <= hvalid_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_ie_q   <= rx_ie_d;
            tx_drop_q <= tx_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= bus.bus_wdata;
    end

    assign rx_cnt9 = 9'(rx_cnt_q);
    assign rxcount = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];
    assign status  = {4'b0000, tx_drop_q, tx_empty, ~tx_full, ~rx_empty};

    always_comb begin
        case (bus.bus_a)
            2'd0:    rd_mux = status;
            2'd1:    rd_mux = data_rd_val;
            2'd2:    rd_mux = {7'b0000000, rx_ie_q};
            default: rd_mux = rxcount;
        endcase
    end

    // Gated by nrst so wait and data drop the instant reset asserts.
    assign bus.bus_rdata = (nrst & bus.bus_cs & bus.bus_oe) ? rd_mux : 8'h00;
    assign bus.bus_wait  = nrst & (rd_wait | tx_stall);

    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp_q];
    assign irq      = rx_ie_q & ~rx_empty;
endmodule

// File: doc/sram_bus_fifo_responder.md
Name: sram_bus_fifo_responder

Overview:
Responder on the AVR external data-memory (SRAM) bus. The AVR subsystem is the initiator on this bus. It decodes a 4-byte register window inside the external-slave range and bridges it to a pair of byte FIFOs. The FIFOs face same-clock fabric logic (e.g. drive/host interface engines). The block drives read data and the bus wait line back to the interconnect; the interconnect gates read data with cs&oe.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of 2, range 2..256
READ_WS, 1, wait cycles inserted on DATA reads; range 0..3
STATUS_RESET, 8'h00, value of sticky/control bits after reset (only bit3 meaningful)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
bus_a  in  2  low address bits of the window (base decode is external, qualified by bus_cs)
bus_wdata  in  8  write data from initiator
bus_cs  in  1  window select
bus_oe  in  1  read strobe
bus_we  in  1  write strobe
bus_rdata  out  8  read data to initiator
bus_wait  out  1  stall request to initiator (maps to the interconnect's slave wait input)
rx_data  in  8  fabric -> AVR byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  RX FIFO can accept (= !rx_full)
tx_data  out  8  AVR -> fabric byte (head of TX FIFO)
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  fabric consumes tx_data
irq  out  1  level interrupt: rx non-empty AND ctrl.rx_ie

Behaviour:
- Clock/reset: single clock clk. nrst is asynchronous, active-low. Reset empties both FIFOs and clears all sticky/control bits. Outputs in reset: bus_rdata=0, bus_wait=0, rx_ready=1, tx_valid=0, tx_data=0, irq=0.
- Register map (bus_a):
  - 0 STATUS (RO): b0 rx_nonempty, b1 tx_notfull, b2 tx_empty, b3 tx_drop (sticky), b7:4 = 0.
  - 1 DATA: read pops RX; write pushes TX.
  - 2 CTRL (RW): b0 rx_ie. b1 flush (write-1 self-clears, reads 0): empties both FIFOs next edge. b3 write-1 clears tx_drop.
  - 3 RXCOUNT (RO): RX occupancy, saturating to 8 bits.
- Non-DATA reads: zero wait, bus_rdata combinational from bus_a and register state.
- Writes: zero wait. They complete on the edge where bus_cs&bus_we.
- DATA read sequence, READ_WS=N:
  - Access starts on the first cycle bus_cs&bus_oe&bus_a==1. bus_wait=1 for N cycles. A wait counter runs IDLE -> WAIT(N) -> DONE.
  - In the DONE cycle bus_wait=0, bus_rdata=RX head registered at access start. The pop occurs on that edge.
  - If strobes are still asserted the cycle after DONE, this is a new access; the counter restarts.
  - N=0: head is combinational; pop on the same edge.
- Empty DATA read: same wait timing, returns 8'h00, no pop, no pointer change.
- RX push: accepted on rx_valid&rx_ready. rx_ready uses registered full, so a push to a full FIFO is refused even if a pop happens on the same edge. Simultaneous push and pop when not full leaves count unchanged.
- TX pop: on tx_valid&tx_ready. A TX write when full is handled as described under Optional Feature.
- Flush coincident with push or pop: flush wins; FIFOs are empty after the edge.
- Pointers: log2(FIFO_DEPTH) bits with natural wrap; counts are log2+1 bits.
- Strobe deasserted during a WAIT: access aborts, no pop, bus_wait drops next cycle.
- Reset mid-access: wait deasserts immediately (async) and no pop occurs.

Optional Feature:
Macro SRAM_RESP_WRSTALL_EN.
- Defined: DATA write with TX full asserts bus_wait, holding the write until a tx pop frees space. The push happens on the first edge where space exists and bus_wait=0. tx_drop never sets.
- Undefined: write to full TX is dropped with zero wait, and tx_drop sets.

Test Plan:
- Reset, then read STATUS -> 8'h06, bus_wait=0. Read RXCOUNT -> 0. irq=0.
- Push rx 8'hA5, 8'h3C via rx_valid. With READ_WS=1, read DATA -> bus_wait high 1 cycle, then rdata 8'hA5; next access returns 8'h3C, RXCOUNT=0.
- Push 16 bytes -> rx_ready=0, RXCOUNT=16. A 17th rx_valid is refused. Pop 1 -> rx_ready=1 the following cycle.
- Write 17 bytes to DATA with tx_ready=0. Undefined macro -> STATUS b3=1, tx_data=first byte. Defined -> bus_wait held high on the 17th until one tx_ready pulse, then push.
- Set CTRL=8'h01 with empty RX -> irq=0. Push one byte -> irq=1 next cycle. Write CTRL=8'h03 (flush) -> RX/TX empty, irq=0.
- Deassert nrst during the WAIT of a DATA read -> bus_wait=0 at once. After reset, RXCOUNT=0 and STATUS=8'h06.
